// File: rtl/mcpu_pipe_pkg.sv
// Shared types and helpers for the multi-cycle CPU pipeline registers.
// Default widths, beat bundle and a saturating increment.
package mcpu_pipe_pkg;

    localparam int PIPE_WIDTH = 32;
    localparam int PIPE_CNT_W = 16;

    typedef struct packed {
        logic                  valid;
        logic [PIPE_WIDTH-1:0] data;
    } pipe_beat_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] max;
        max = 32'hFFFF_FFFF >> (32 - w);
        return (v >= max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Second holding register for pipe_stage_reg: catches the beat accepted
// while the main register is stalled, so in_ready can come from a flop.
module pipe_skid_buf
    import mcpu_pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             pop,
    input  logic [WIDTH-1:0] in_data,
    output logic             skid_valid,
    output logic [WIDTH-1:0] skid_data
);

    // Capture on load, release on pop; flush drops the beat, keeps the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_data  <= RESET_VAL;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (load) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end else if (pop) begin
            skid_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with flush and stall counter.
// Define PIPE_STAGE_REG_SKID_EN to build the skid buffer (registered in_ready).
module pipe_stage_reg
    import mcpu_pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             load_main;
    logic             accept;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    assign load_main = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
    // Ready depends only on the skid flop, never on out_ready.
    assign in_ready = ~skid_valid & ~flush & ~rst;

    pipe_skid_buf #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load       (~load_main & accept),
        .pop        (load_main & skid_valid),
        .in_data    (in_data),
        .skid_valid (skid_valid),
        .skid_data  (skid_data)
    );
`else
    // Single-entry build: ready follows the downstream combinationally.
    assign in_ready   = load_main & ~flush & ~rst;
    assign skid_valid = 1'b0;
    assign skid_data  = RESET_VAL;
`endif

    // Main register: refill from skid first, else from the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= RESET_VAL;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_main) begin
            if (skid_valid) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= in_data;
                end
            end
        end
    end

    // Saturating count of cycles a beat waits on the downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (out_valid & ~out_ready) begin
            stall_cnt <= CNT_W'(sat_inc(32'(stall_cnt), CNT_W));
        end
    end

endmodule
